acslip_sample_adjust: RTL and testbench

Consumer-side partner of the FLL ACSLIP slip counter. It sits in the 16 kHz mic sample stream between the decimator output and the I2S TX FIFO. It reads the signed slip count and keeps the two clock domains aligned by duplicating one sample when the I2S side runs ahead, or dropping one sample when it lags. It also maintains insert/drop status counters for firmware.

---
 rtl/acslip_pkg.sv | 20 ++
 rtl/sat_cnt16.sv | 44 ++++
 rtl/acslip_sample_adjust.sv | 181 ++++++++++++++++++
 tb/tb_acslip_sample_adjust.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acslip_pkg.sv
// ----------------------------------------------------------------------------
// acslip_pkg
// Shared types and constants for the ACSLIP sample adjuster:
//   adj_state_e          : sample adjuster FSM states
//   ACSLIP_THRESH_DEF    : default residual-slip threshold for a correction
//   ACSLIP_HOLDOFF_DEF   : default number of plain samples between corrections
//   STAT_W               : width of the insert/drop status counters
// ----------------------------------------------------------------------------
package acslip_pkg;

   typedef enum logic {
      S_PASS = 1'b0,
      S_DUP  = 1'b1
   } adj_state_e;

   localparam int unsigned ACSLIP_THRESH_DEF  = 2;
   localparam int unsigned ACSLIP_HOLDOFF_DEF = 4;
   localparam int unsigned STAT_W             = 16;

endpackage : acslip_pkg

// File: rtl/sat_cnt16.sv
// ----------------------------------------------------------------------------
// sat_cnt16
// 16-bit up counter that sticks at all-ones; synchronous clear wins over inc.
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   clr_i   : synchronous clear
//   inc_i   : increment request (ignored once saturated)
//   cnt_o   : registered count
// ----------------------------------------------------------------------------
module sat_cnt16
   import acslip_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [STAT_W-1:0] cnt_o
);

   logic [STAT_W-1:0] cnt_q;
   logic [STAT_W-1:0] cnt_d;

   // Next count: clear first, otherwise increment until saturated
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : sat_cnt16

// File: rtl/acslip_sample_adjust.sv
// ----------------------------------------------------------------------------
// acslip_sample_adjust
// Sits in the 16 kHz mic sample stream between the decimator and the I2S TX
// FIFO. Compares the FLL slip count against the corrections already applied
// and duplicates one sample (I2S side ahead) or drops one sample (I2S side
// behind) to keep the two clock domains aligned.
//
// Build option: define ACSLIP_ADJ_STATUS_EN to get live saturating
// insert/drop counters; otherwise ins_cnt_o/drop_cnt_o read 16'h0000.
//
// Ports:
//   wbs_clk_i, wbs_rst_n_i : clock, asynchronous active-low reset
//   adj_en_i               : correction enable (low = pure pass-through)
//   acslip_reg_i           : signed slip count from the slip counter
//   acslip_reg_rst_i       : slip counter clear pulse, zeroes corr
//   in_dat_i/in_vld_i/in_rdy_o    : upstream sample handshake
//   out_dat_o/out_vld_o/out_rdy_i : downstream sample handshake (registered)
//   ins_cnt_o, drop_cnt_o  : saturating status counters
// ----------------------------------------------------------------------------
module acslip_sample_adjust
   import acslip_pkg::*;
#(
   parameter int unsigned ACSLIP_REG_WIDTH = 32,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned THRESH           = ACSLIP_THRESH_DEF,
   parameter int unsigned HOLDOFF          = ACSLIP_HOLDOFF_DEF
) (
   input  logic                        wbs_clk_i,
   input  logic                        wbs_rst_n_i,
   input  logic                        adj_en_i,
   input  logic [ACSLIP_REG_WIDTH-1:0] acslip_reg_i,
   input  logic                        acslip_reg_rst_i,
   input  logic [DATA_WIDTH-1:0]       in_dat_i,
   input  logic                        in_vld_i,
   output logic                        in_rdy_o,
   output logic [DATA_WIDTH-1:0]       out_dat_o,
   output logic                        out_vld_o,
   input  logic                        out_rdy_i,
   output logic [STAT_W-1:0]           ins_cnt_o,
   output logic [STAT_W-1:0]           drop_cnt_o
);

   localparam int unsigned AW     = ACSLIP_REG_WIDTH;
   localparam int unsigned HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   localparam logic signed [AW-1:0] THR_P = AW'(THRESH);
   localparam logic signed [AW-1:0] THR_N = -THR_P;
   localparam logic signed [AW-1:0] ONE_S = AW'(1);

   adj_state_e               state_q, state_d;
   logic [DATA_WIDTH-1:0]    out_dat_q, out_dat_d;
   logic                     out_vld_q, out_vld_d;
   logic signed [AW-1:0]     corr_q, corr_d;
   logic [HOLD_W-1:0]        hold_q, hold_d;
   logic signed [AW-1:0]     acslip_q;

   logic signed [AW-1:0]     err_c;
   logic                     ins_req_c;
   logic                     drop_req_c;
   logic                     out_hs_c;
   logic                     in_acc_c;
   logic                     in_rdy_c;
   logic                     ins_evt_c;
   logic                     drop_evt_c;

   // Residual slip not yet corrected; wraps modulo 2^AW, read as signed
   assign err_c      = acslip_q - corr_q;
   assign ins_req_c  = adj_en_i & (err_c >= THR_P) & (hold_q == '0);
   assign drop_req_c = adj_en_i & (err_c <= THR_N) & (hold_q == '0);
   assign out_hs_c   = out_vld_q & out_rdy_i;

   // Next-state and datapath decisions
   always_comb begin
      state_d    = state_q;
      out_dat_d  = out_dat_q;
      out_vld_d  = out_vld_q;
      corr_d     = corr_q;
      hold_d     = hold_q;
      in_rdy_c   = 1'b0;
      in_acc_c   = 1'b0;
      ins_evt_c  = 1'b0;
      drop_evt_c = 1'b0;

      unique case (state_q)
         S_PASS: begin
            in_rdy_c = ~out_vld_q | out_rdy_i;
            in_acc_c = in_vld_i & in_rdy_c;
            if (in_acc_c && drop_req_c) begin
               // Discard the sample; the output slot is empty or draining now
               out_vld_d  = 1'b0;
               corr_d     = corr_q - ONE_S;
               drop_evt_c = 1'b1;
               hold_d     = HOLD_W'(HOLDOFF);
            end else if (in_acc_c) begin
               out_dat_d = in_dat_i;
               out_vld_d = 1'b1;
               if (hold_q != '0) begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end else if (out_hs_c) begin
               // Insert only on a handshake with no concurrent load
               if (ins_req_c) begin
                  state_d   = S_DUP;
                  out_vld_d = 1'b1;
               end else begin
                  out_vld_d = 1'b0;
               end
            end
         end

         S_DUP: begin
            out_vld_d = 1'b1;
            if (out_rdy_i) begin
               corr_d    = corr_q + ONE_S;
               ins_evt_c = 1'b1;
               hold_d    = HOLD_W'(HOLDOFF);
               out_vld_d = 1'b0;
               state_d   = S_PASS;
            end
         end

         default: begin
            state_d   = S_PASS;
            out_vld_d = 1'b0;
         end
      endcase

      // Counter clear or disable overrides any same-cycle +/-1
      if (acslip_reg_rst_i || !adj_en_i) begin
         corr_d = '0;
      end
   end

   // State and datapath registers
   always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
      if (!wbs_rst_n_i) begin
         state_q   <= S_PASS;
         out_dat_q <= '0;
         out_vld_q <= 1'b0;
         corr_q    <= '0;
         hold_q    <= '0;
         acslip_q  <= '0;
      end else begin
         state_q   <= state_d;
         out_dat_q <= out_dat_d;
         out_vld_q <= out_vld_d;
         corr_q    <= corr_d;
         hold_q    <= hold_d;
         acslip_q  <= acslip_reg_i;
      end
   end

   assign in_rdy_o  = in_rdy_c;
   assign out_dat_o = out_dat_q;
   assign out_vld_o = out_vld_q;

`ifdef ACSLIP_ADJ_STATUS_EN
   // Firmware-visible insert/drop counters, cleared only by reset
   sat_cnt16 u_ins_cnt (
      .clk_i   (wbs_clk_i),
      .rst_n_i (wbs_rst_n_i),
      .clr_i   (1'b0),
      .inc_i   (ins_evt_c),
      .cnt_o   (ins_cnt_o)
   );

   sat_cnt16 u_drop_cnt (
      .clk_i   (wbs_clk_i),
      .rst_n_i (wbs_rst_n_i),
      .clr_i   (1'b0),
      .inc_i   (drop_evt_c),
      .cnt_o   (drop_cnt_o)
   );
`else
   logic unused_evt_c;
   assign unused_evt_c = ins_evt_c ^ drop_evt_c;
   assign ins_cnt_o    = '0;
   assign drop_cnt_o   = '0;
`endif

endmodule : acslip_sample_adjust

// File: tb/tb_acslip_sample_adjust.sv
// ----------------------------------------------------------------------------
// tb_acslip_sample_adjust
// Directed stimulus with a scoreboard: each scenario pushes the samples it
// expects to see downstream; a negedge monitor pops and compares on every
// output handshake. Status counter expectations follow ACSLIP_ADJ_STATUS_EN.
// ----------------------------------------------------------------------------
module tb_acslip_sample_adjust;
   import acslip_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 16;

`ifdef ACSLIP_ADJ_STATUS_EN
   localparam bit STAT_ON = 1'b1;
`else
   localparam bit STAT_ON = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              adj_en;
   logic [AW-1:0]     acslip;
   logic              acslip_rst;
   logic [DW-1:0]     in_dat;
   logic              in_vld;
   logic              in_rdy;
   logic [DW-1:0]     out_dat;
   logic              out_vld;
   logic              out_rdy;
   logic [STAT_W-1:0] ins_cnt;
   logic [STAT_W-1:0] drop_cnt;

   logic              sat_clr;
   logic              sat_inc;
   logic [STAT_W-1:0] sat_cnt;

   int                checks;
   int                errors;
   logic [DW-1:0]     exp_q[$];
   logic [DW-1:0]     mon_e;

   acslip_sample_adjust #(
      .ACSLIP_REG_WIDTH (AW),
      .DATA_WIDTH       (DW),
      .THRESH           (2),
      .HOLDOFF          (4)
   ) dut (
      .wbs_clk_i        (clk),
      .wbs_rst_n_i      (rst_n),
      .adj_en_i         (adj_en),
      .acslip_reg_i     (acslip),
      .acslip_reg_rst_i (acslip_rst),
      .in_dat_i         (in_dat),
      .in_vld_i         (in_vld),
      .in_rdy_o         (in_rdy),
      .out_dat_o        (out_dat),
      .out_vld_o        (out_vld),
      .out_rdy_i        (out_rdy),
      .ins_cnt_o        (ins_cnt),
      .drop_cnt_o       (drop_cnt)
   );

   sat_cnt16 u_sat (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .clr_i   (sat_clr),
      .inc_i   (sat_inc),
      .cnt_o   (sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] stat_exp(input int n);
      return STAT_ON ? 32'(n) : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every downstream handshake must match the queue head
   always @(negedge clk) begin
      if (rst_n && out_vld && out_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: actual=%h required=none", out_dat);
         end else begin
            mon_e = exp_q.pop_front();
            if (out_dat !== mon_e) begin
               errors++;
               $display("FAIL sb_data: actual=%h required=%h", out_dat, mon_e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one sample and hold it until accepted; returns just after the accepting edge
   task automatic send(input logic [DW-1:0] d);
      int n;
      n      = 0;
      in_dat = d;
      in_vld = 1'b1;
      @(negedge clk);
      while (!in_rdy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("send_accept", 32'(in_rdy), 32'h1);
      @(posedge clk);
      #1;
      in_vld = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 32'(exp_q.size()), 32'h0);
      idle(2);
   endtask

   task automatic pulse_clr();
      acslip_rst = 1'b1;
      idle(1);
      acslip_rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b1;
      adj_en     = 1'b0;
      acslip     = '0;
      acslip_rst = 1'b0;
      in_dat     = '0;
      in_vld     = 1'b0;
      out_rdy    = 1'b1;
      sat_clr    = 1'b0;
      sat_inc    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_vld", 32'(out_vld), 32'h0);
      chk("rst_out_dat", 32'(out_dat), 32'h0);
      chk("rst_in_rdy",  32'(in_rdy),  32'h1);
      chk("rst_ins_cnt", 32'(ins_cnt), 32'h0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Pass-through with correction disabled despite a large slip
      adj_en = 1'b0;
      acslip = 32'd100;
      idle(2);
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back(DW'(i));
         send(DW'(i));
         if (i == 1) begin
            chk("pass_latency_vld", 32'(out_vld), 32'h1);
            chk("pass_latency_dat", 32'(out_dat), 32'h1);
         end
      end
      drain();
      chk("pass_ins_cnt",  32'(ins_cnt),  32'h0);
      chk("pass_drop_cnt", 32'(drop_cnt), 32'h0);

      // Insert: err = 2 duplicates the next sample once, then err = 1 stops it
      adj_en = 1'b1;
      acslip = 32'd2;
      idle(2);
      exp_q.push_back(16'h0100);
      exp_q.push_back(16'h0100);
      send(16'h0100);
      drain();
      chk("ins_cnt_1", 32'(ins_cnt), stat_exp(1));
      for (int i = 1; i <= 6; i++) begin
         exp_q.push_back(16'h0100 + DW'(i));
         send(16'h0100 + DW'(i));
         idle(2);
      end
      drain();
      chk("ins_cnt_no_more", 32'(ins_cnt), stat_exp(1));

      // Drop: err = -3, second drop after four passed samples, then err = -1
      pulse_clr();
      acslip = 32'hFFFF_FFFD;
      idle(2);
      for (int i = 1; i <= 9; i++) begin
         if (i != 5) exp_q.push_back(16'h0200 + DW'(i));
      end
      for (int i = 0; i <= 9; i++) begin
         send(16'h0200 + DW'(i));
      end
      drain();
      chk("drop_cnt_2", 32'(drop_cnt), stat_exp(2));
      chk("drop_ins_cnt", 32'(ins_cnt), stat_exp(1));

      // Backpressure during the duplicate
      pulse_clr();
      acslip = 32'd2;
      idle(2);
      out_rdy = 1'b0;
      exp_q.push_back(16'h0300);
      exp_q.push_back(16'h0300);
      exp_q.push_back(16'h0301);
      send(16'h0300);
      out_rdy = 1'b1;
      @(posedge clk);
      #1;
      out_rdy = 1'b0;
      in_dat  = 16'h0301;
      in_vld  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("dup_hold_vld", 32'(out_vld), 32'h1);
         chk("dup_hold_dat", 32'(out_dat), 32'h0300);
         chk("dup_in_rdy",   32'(in_rdy),  32'h0);
      end
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      @(negedge clk);
      chk("dup_in_rdy_ready", 32'(in_rdy), 32'h0);
      send(16'h0301);
      drain();
      chk("dup_ins_cnt_2", 32'(ins_cnt), stat_exp(2));

      // Clear pulse coinciding with a drop: corr ends at 0, so a later drop still fires
      acslip = 32'd1;
      idle(2);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(16'h0400 + DW'(i));
         send(16'h0400 + DW'(i));
      end
      drain();
      acslip = 32'hFFFF_FFFE;
      idle(2);
      acslip_rst = 1'b1;
      send(16'h0500);
      acslip_rst = 1'b0;
      chk("clr_drop_cnt_3", 32'(drop_cnt), stat_exp(3));
      for (int i = 1; i <= 6; i++) begin
         if (i != 5) exp_q.push_back(16'h0500 + DW'(i));
      end
      for (int i = 1; i <= 6; i++) begin
         send(16'h0500 + DW'(i));
      end
      drain();
      chk("clr_drop_cnt_4", 32'(drop_cnt), stat_exp(4));

      // Asynchronous reset while a duplicate is pending
      acslip = 32'hFFFF_FFFF;
      idle(2);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(16'h0600 + DW'(i));
         send(16'h0600 + DW'(i));
      end
      drain();
      acslip = 32'd5;
      idle(2);
      exp_q.push_back(16'h0700);
      send(16'h0700);
      @(posedge clk);
      #1;
      chk("dup_pending_vld", 32'(out_vld), 32'h1);
      chk("dup_pending_rdy", 32'(in_rdy),  32'h0);
      chk("dup_pending_dat", 32'(out_dat), 32'h0700);
      chk("pre_rst_ins_cnt",  32'(ins_cnt),  stat_exp(2));
      chk("pre_rst_drop_cnt", 32'(drop_cnt), stat_exp(4));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_vld", 32'(out_vld), 32'h0);
      chk("mid_rst_in_rdy",  32'(in_rdy),  32'h1);
      chk("mid_rst_out_dat", 32'(out_dat), 32'h0);
      chk("mid_rst_ins",     32'(ins_cnt), 32'h0);
      chk("mid_rst_drop",    32'(drop_cnt), 32'h0);
      chk("mid_rst_sb",      32'(exp_q.size()), 32'h0);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // After reset hold_cnt and corr are zero, so err = 5 inserts at once
      exp_q.push_back(16'h0800);
      exp_q.push_back(16'h0800);
      send(16'h0800);
      drain();
      chk("post_rst_ins_cnt", 32'(ins_cnt), stat_exp(1));

      // Saturating counter: clear, count to the top, stay there, clear again
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      chk("sat_clr0", 32'(sat_cnt), 32'h0);
      sat_inc = 1'b1;
      idle(65534);
      chk("sat_fffe", 32'(sat_cnt), 32'h0000_FFFE);
      idle(1);
      chk("sat_ffff", 32'(sat_cnt), 32'h0000_FFFF);
      idle(5);
      chk("sat_hold", 32'(sat_cnt), 32'h0000_FFFF);
      sat_clr = 1'b1;
      idle(1);
      sat_clr = 1'b0;
      sat_inc = 1'b0;
      chk("sat_clr1", 32'(sat_cnt), 32'h0);

      chk("sb_empty_end", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_acslip_sample_adjust
